// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding a small first-word-fall-through FIFO
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reset    asynchronous active-low reset
//   rxd      serial input, idles high, asynchronous to clk
//   IOread   active-low read strobe: pops the FIFO head when non-empty, clears sticky flags
//   dataout  FIFO head value, 0 when empty
//   RXready  FIFO non-empty
//   overrun  sticky: a received byte was dropped because the FIFO was full
//   framerr  sticky: a stop bit was sampled low
module uart_rx #(
    parameter int ClkPerBit    = 16,
    parameter int WordSize     = 8,
    parameter int FifoAddrSize = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rxd,
    input  logic                IOread,
    output logic [WordSize-1:0] dataout,
    output logic                RXready,
    output logic                overrun,
    output logic                framerr
);
    localparam int TW    = $clog2(ClkPerBit);
    localparam int CW    = WordSize > 1 ? $clog2(WordSize) : 1;
    localparam int AW    = FifoAddrSize + 1;
    localparam int Depth = 1 << FifoAddrSize;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

    state_t              state, next;
    logic [1:0]          sync;
    logic                rxs;
    logic [TW-1:0]       timer;
    logic [CW-1:0]       bitcnt;
    logic [WordSize-1:0] shreg;
    logic                half_tick, full_tick, last_bit, tmr_clr;
    logic                shift_en, push, ferr_set;
    logic [WordSize-1:0] mem [Depth];
    logic [AW-1:0]       wp, rp;
    logic                empty, full, pop, wr, ovr_set;

    always_ff @(posedge clk or negedge reset)
        if (!reset) sync <= 2'b11;
        else        sync <= {sync[0], rxd};

    assign rxs       = sync[1];
    assign half_tick = timer == TW'(ClkPerBit / 2 - 1);
    assign full_tick = timer == TW'(ClkPerBit - 1);
    assign last_bit  = bitcnt == CW'(WordSize - 1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = rxs ? IDLE : START;
            START:   next = half_tick ? (rxs ? IDLE : DATA) : START;
            DATA:    next = (full_tick && last_bit) ? STOP : DATA;
            STOP:    next = full_tick ? (rxs ? IDLE : WAITHI) : STOP;
            WAITHI:  next = rxs ? IDLE : WAITHI;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        shift_en = (state == DATA) && full_tick;
        push     = (state == STOP) && full_tick && rxs;
        ferr_set = (state == STOP) && full_tick && !rxs;
        // timer restarts at the start edge, at mid start bit, and at every bit-centre sample
        tmr_clr  = (state == IDLE) || ((state == START) && half_tick) || full_tick;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            timer  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            timer  <= tmr_clr ? '0 : timer + TW'(1);
            bitcnt <= (state != DATA) ? '0 : shift_en ? bitcnt + CW'(1) : bitcnt;
            shreg  <= shift_en ? {rxs, shreg[WordSize-1:1]} : shreg;
        end

    assign empty   = wp == rp;
    assign full    = (wp[FifoAddrSize] != rp[FifoAddrSize]) &&
                     (wp[FifoAddrSize-1:0] == rp[FifoAddrSize-1:0]);
    assign pop     = !IOread && !empty;
    // a pop on the same edge frees the head slot, so a full FIFO still accepts the byte
    assign wr      = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_ff @(posedge clk)
        if (wr) mem[wp[FifoAddrSize-1:0]] <= shreg;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp      <= '0;
            rp      <= '0;
            overrun <= 1'b0;
            framerr <= 1'b0;
        end else begin
            wp      <= wp + AW'(wr);
            rp      <= rp + AW'(pop);
            overrun <= ovr_set | (overrun & IOread);
            framerr <= ferr_set | (framerr & IOread);
        end

    assign dataout = empty ? '0 : mem[rp[FifoAddrSize-1:0]];
    assign RXready = !empty;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a queue-based receiver model, checked every cycle
module tb_uart_rx;
    localparam int CPB     = 16;
    localparam int STOP_AT = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset, rxd, IOread;
    logic [7:0] dataout;
    logic       RXready, overrun, framerr;

    uart_rx #(.ClkPerBit(CPB), .WordSize(8), .FifoAddrSize(2)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .IOread(IOread),
        .dataout(dataout), .RXready(RXready), .overrun(overrun), .framerr(framerr)
    );

    always #5 clk = ~clk;

    typedef struct {int c; bit ok; logic [7:0] b;} ev_t;

    ev_t        ev[$];
    logic [7:0] q[$];
    bit         m_ovr = 1'b0, m_ferr = 1'b0;
    int         cyc = 0, total = 0, bad = 0, rise_cyc = -1, n0 = 0;
    logic       prev_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Receiver behaviour: each frame resolves at its stop-sample cycle into a push or a framing error.
    task automatic model_step();
        bit         push, ferr, ovr, pop, isfull;
        logic [7:0] pb;
        cyc++;
        if (reset !== 1'b1) begin
            q.delete();
            ev.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            return;
        end
        push = 1'b0;
        ferr = 1'b0;
        ovr  = 1'b0;
        pb   = 8'h00;
        for (int i = ev.size() - 1; i >= 0; i--)
            if (ev[i].c == cyc) begin
                if (ev[i].ok) begin
                    push = 1'b1;
                    pb   = ev[i].b;
                end else ferr = 1'b1;
                ev.delete(i);
            end
        isfull = q.size() == 4;
        pop    = (IOread === 1'b0) && (q.size() > 0);
        if (pop) q.delete(0);
        if (push) begin
            if (!isfull || pop) q.push_back(pb);
            else ovr = 1'b1;
        end
        if (ovr) m_ovr = 1'b1;
        else if (IOread === 1'b0) m_ovr = 1'b0;
        if (ferr) m_ferr = 1'b1;
        else if (IOread === 1'b0) m_ferr = 1'b0;
    endtask

    task automatic compare();
        check("dataout", 32'(dataout), (q.size() > 0) ? 32'(q[0]) : 32'h0);
        check("RXready", 32'(RXready), 32'(q.size() > 0));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("framerr", 32'(framerr), 32'(m_ferr));
        if (RXready === 1'b1 && prev_rdy !== 1'b1) rise_cyc = cyc;
        prev_rdy = RXready;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
        @(negedge clk);
    endtask

    // Leaves rxd at the stop-bit level; pop_stop pulls IOread low on the stop-sample edge only.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit pop_stop);
        int n;
        n = cyc;
        ev.push_back('{n + STOP_AT, stop, b});
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) tick();
        end
        rxd = stop;
        for (int k = 0; k < CPB; k++) begin
            IOread = !(pop_stop && cyc == n + STOP_AT - 1);
            tick();
        end
        IOread = 1'b1;
    endtask

    task automatic read_byte(input logic [7:0] exp, input string name);
        check(name, 32'(dataout), 32'(exp));
        IOread = 1'b0;
        tick();
        IOread = 1'b1;
        tick();
    endtask

    initial begin
        reset  = 1'b0;
        rxd    = 1'b1;
        IOread = 1'b1;
        repeat (3) tick();
        check("rst_dataout", 32'(dataout), 0);
        check("rst_rdy", 32'(RXready), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_ferr", 32'(framerr), 0);
        reset = 1'b1;
        repeat (4) tick();

        n0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_rise", 32'(rise_cyc - n0), 155);
        check("a5_data", 32'(dataout), 32'hA5);
        check("a5_rdy", 32'(RXready), 1);
        IOread = 1'b0;
        tick();
        IOread = 1'b1;
        check("a5_rdy_pop", 32'(RXready), 0);
        check("a5_data_pop", 32'(dataout), 0);
        repeat (4) tick();

        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        repeat (40) tick();
        check("glitch_rdy", 32'(RXready), 0);
        check("glitch_ferr", 32'(framerr), 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        read_byte(8'h3C, "rd_3c");

        send_frame(8'h81, 1'b0, 1'b0);
        check("brk_ferr", 32'(framerr), 1);
        check("brk_rdy", 32'(RXready), 0);
        repeat (300) tick();
        IOread = 1'b0;
        tick();
        IOread = 1'b1;
        repeat (323) tick();
        check("brk_once", 32'(framerr), 0);
        rxd = 1'b1;
        repeat (20) tick();
        check("brk_once_hi", 32'(framerr), 0);
        send_frame(8'h42, 1'b1, 1'b0);
        read_byte(8'h42, "rd_42");
        check("rd_42_empty", 32'(RXready), 0);

        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0);
        check("ovr_set", 32'(overrun), 1);
        check("ovr_head", 32'(dataout), 1);
        read_byte(8'h01, "ovr_rd1");
        check("ovr_clr", 32'(overrun), 0);
        read_byte(8'h02, "ovr_rd2");
        read_byte(8'h03, "ovr_rd3");
        read_byte(8'h04, "ovr_rd4");
        check("ovr_empty", 32'(RXready), 0);

        for (int b = 16; b <= 19; b++) send_frame(8'(b), 1'b1, 1'b0);
        send_frame(8'h14, 1'b1, 1'b1);
        check("full_pop_ovr", 32'(overrun), 0);
        read_byte(8'h11, "full_rd11");
        read_byte(8'h12, "full_rd12");
        read_byte(8'h13, "full_rd13");
        read_byte(8'h14, "full_rd14");
        check("full_empty", 32'(RXready), 0);

        send_frame(8'h77, 1'b1, 1'b0);
        check("pre_rst_rdy", 32'(RXready), 1);
        rxd = 1'b0;
        repeat (CPB) tick();
        rxd = 1'b1;
        repeat (3 * CPB) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("mid_rst_data", 32'(dataout), 0);
        check("mid_rst_rdy", 32'(RXready), 0);
        check("mid_rst_ovr", 32'(overrun), 0);
        check("mid_rst_ferr", 32'(framerr), 0);
        reset = 1'b1;
        repeat (20) tick();
        check("post_rst_rdy", 32'(RXready), 0);
        send_frame(8'h66, 1'b1, 1'b0);
        read_byte(8'h66, "rd_66");
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
